muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide unit with its own sequencer, alongside the execute stage. It accepts MULT/MULTU/DIV/DIVU from the execute stage, with operands taken after the forwarding muxes. It runs one bit per cycle, keeps the architectural HI/LO registers, and raises a stall to freeze the pipeline while a HI/LO consumer or a new mul/div arrives during an operation. It also services MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO path.

## Interface
- LEN, 32, datapath width; iteration count equals LEN
- NB_OP, 2, width of operation code
- i_clk  in  1  clock; all state updates on falling edge, matching the pipeline latches
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  mul/div instruction in execute this cycle
- i_op  in  NB_OP  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- i_dato_a  in  LEN  rs operand (post-forwarding); multiplicand / dividend
- i_dato_b  in  LEN  rt operand (post-forwarding); multiplier / divisor
- i_hilo_rd  in  1  MFHI/MFLO present in decode
- i_hilo_wr  in  2  bit1 MTHI, bit0 MTLO
- i_hilo_wdata  in  LEN  data for MTHI/MTLO
- o_busy  out  1  operation in progress
- o_stall  out  1  pipeline freeze request, combinational
- o_done  out  1  one-cycle pulse, HI/LO just updated by an operation
- o_div_zero  out  1  valid with o_done; last division had divisor 0
- o_hi  out  LEN  HI register
- o_lo  out  LEN  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- **IDLE**
  - i_start=1: latch op, operand magnitudes (signed ops) and result signs; clear the counter; go to RUN.
  - Any i_hilo_wr bit set together with i_start: the write is discarded.
  - i_hilo_wr only: write the selected HI and/or LO from i_hilo_wdata.
- **RUN**
  - One iteration per edge; the counter runs 0..LEN-1; go to FIX after iteration LEN-1.
  - Multiply: shift-add on a 2·LEN-bit accumulator.
  - Divide: restoring, one quotient bit per edge, on a LEN+1-bit partial remainder.
- **FIX**
  - Apply sign correction.
  - Write HI/LO:
    - Multiply: HI = upper product, LO = lower product.
    - Divide: HI = remainder, LO = quotient.
  - Assert o_done and o_div_zero for the following cycle; return to IDLE.
- Signed rules:
  - Product is the full 2·LEN-bit two's-complement result.
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0; no flag.
- Divide by zero: the sequence runs normally. Result is HI=i_dato_a (as latched), LO=all ones, o_div_zero=1.
- While RUN or FIX:
  - i_start is ignored; no restart, and latched operands are unchanged.
  - i_hilo_wr is ignored.
- o_stall = o_busy & (i_hilo_rd | i_start).
- o_hi/o_lo change only on MTHI/MTLO in IDLE or on the FIX edge; partial results are never visible.

## Timing
- Reset, async:
  - State = IDLE, HI=LO=0.
  - o_busy=o_done=o_div_zero=0, counter=0.
  - Takes effect immediately, including mid-RUN; the operation is abandoned and HI/LO read 0.
- Latency:
  - Edge E0 samples i_start.
  - Edges E1..E(LEN) are iterations.
  - Edge E(LEN+1) is FIX and writes HI/LO.
  - For LEN=32, HI/LO are valid after E33, and o_done is high for the cycle between E33 and E34.
- o_busy:
  - Goes high after E0.
  - Goes low after E(LEN+1) (the FIX edge), together with o_done rising.
  - A new i_start is accepted on E(LEN+2) at the earliest.
- MFHI in decode during the o_done cycle does not stall and reads the new HI.
- o_done and o_div_zero deassert on the next edge.

## Test plan
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; o_done exactly in the cycle after edge 33; o_busy high for 33 cycles.
- MULT with a=-3, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV with a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV with a=0x80000000, b=-1 -> LO=0x80000000, HI=0.
- DIVU with a=10, b=0 -> HI=0x0000000A, LO=0xFFFFFFFF, o_div_zero=1 with o_done.
- During RUN: i_hilo_rd=1 -> o_stall=1 every cycle until o_done. i_start with new operands -> ignored, result from original operands. i_hilo_wr=01 -> LO unaffected.
- In IDLE: MTHI 0x1234 then MTLO 0x5678 -> o_hi=0x1234, o_lo=0x5678. MTLO together with i_start -> write discarded, operation starts.
- Assert i_rst between falling edges at iteration 10 -> outputs reset immediately (HI=LO=0, busy=0); after release a fresh MULTU 6×7 -> LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with its own sequencer and the architectural
// HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from execute and computes
// one bit per falling clock edge. It also services MTHI/MTLO and requests a
// pipeline stall while a HI/LO consumer or another mul/div arrives mid-operation.
//
// Ports:
//   i_clk          clock; state updates on the falling edge
//   i_rst          asynchronous active-high reset
//   i_start        mul/div instruction in execute this cycle
//   i_op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   i_dato_a/b     rs/rt operands (post-forwarding)
//   i_hilo_rd      MFHI/MFLO present in decode
//   i_hilo_wr      bit1 MTHI, bit0 MTLO
//   i_hilo_wdata   MTHI/MTLO data
//   o_busy         operation in progress
//   o_stall        pipeline freeze request (combinational)
//   o_done         one-cycle pulse after HI/LO are written by an operation
//   o_div_zero     valid with o_done; the divisor was zero
//   o_hi/o_lo      HI/LO registers
module muldiv_sequencer #(
  parameter int LEN   = 32,
  parameter int NB_OP = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NB_OP-1:0] i_op,
  input  logic [LEN-1:0]   i_dato_a,
  input  logic [LEN-1:0]   i_dato_b,
  input  logic             i_hilo_rd,
  input  logic [1:0]       i_hilo_wr,
  input  logic [LEN-1:0]   i_hilo_wdata,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [LEN-1:0]   o_hi,
  output logic [LEN-1:0]   o_lo
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  logic [2*LEN-1:0]   r_acc;    // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [LEN-1:0]     r_opd;    // multiplicand or divisor magnitude
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;  // negate product / quotient
  logic               r_neg_r;  // negate remainder (dividend sign)
  logic               r_dz;

  // Operand magnitudes at start
  logic               w_a_neg, w_b_neg;
  logic [LEN-1:0]     w_a_mag, w_b_mag;

  assign w_a_neg = i_op[0] & i_dato_a[LEN-1];
  assign w_b_neg = i_op[0] & i_dato_b[LEN-1];
  assign w_a_mag = w_a_neg ? -i_dato_a : i_dato_a;
  assign w_b_mag = w_b_neg ? -i_dato_b : i_dato_b;

  // Shift-add multiply step: add the multiplicand into the upper half when
  // the multiplier LSB is set, then shift the whole accumulator right.
  logic [LEN:0]       w_mul_sum;
  logic [2*LEN-1:0]   w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*LEN-1:LEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[LEN-1:1]};

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [LEN:0]       w_shift;
  logic               w_fits;
  logic [LEN-1:0]     w_sub;
  logic [2*LEN-1:0]   w_div_next;

  assign w_shift    = {r_acc[2*LEN-1:LEN], r_acc[LEN-1]};
  assign w_fits     = w_shift >= {1'b0, r_opd};
  assign w_sub      = w_shift[LEN-1:0] - r_opd;
  assign w_div_next = {(w_fits ? w_sub : w_shift[LEN-1:0]), r_acc[LEN-2:0], w_fits};

  // Sign correction applied on the FIX edge
  logic [2*LEN-1:0]   w_prod;
  logic [LEN-1:0]     w_quo, w_rem;

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[LEN-1:0] : r_acc[LEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*LEN-1:LEN] : r_acc[2*LEN-1:LEN];

  assign o_stall = o_busy & (i_hilo_rd | i_start);

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_opd      <= '0;
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      o_hi       <= '0;
      o_lo       <= '0;
    end else begin
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_div   <= i_op[1];
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= i_op[1] & w_a_neg;
            r_dz    <= i_op[1] & (i_dato_b == '0);
            r_acc   <= {{LEN{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
            r_opd   <= i_op[1] ? w_b_mag : w_a_mag;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            if (i_hilo_wr[1]) o_hi <= i_hilo_wdata;
            if (i_hilo_wr[0]) o_lo <= i_hilo_wdata;
          end
        end
        RUN: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= FIX;
          end
        end
        FIX: begin
          if (r_div) begin
            // Divide by zero leaves the dividend as remainder naturally;
            // only the quotient needs forcing.
            o_hi <= w_rem;
            o_lo <= r_dz ? '1 : w_quo;
          end else begin
            {o_hi, o_lo} <= w_prod;
          end
          o_done     <= 1'b1;
          o_div_zero <= r_dz;
          o_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int LEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = '0;
  logic [LEN-1:0]  a = '0, b = '0;
  logic            hilo_rd = 1'b0;
  logic [1:0]      hilo_wr = '0;
  logic [LEN-1:0]  wdata = '0;
  logic            busy, stall, done, dz;
  logic [LEN-1:0]  hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_sequencer #(.LEN(LEN), .NB_OP(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_dato_a(a), .i_dato_b(b), .i_hilo_rd(hilo_rd), .i_hilo_wr(hilo_wr),
    .i_hilo_wdata(wdata), .o_busy(busy), .o_stall(stall), .o_done(done),
    .o_div_zero(dz), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {div_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      2'd1: begin q = sx * sy; return {1'b0, q[63:0]}; end
      2'd2: begin
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Transaction-level model: remaining-cycle countdown and pending result
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done, m_dz, p_dz;
  int          m_cnt;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; m_cnt = 0;
    end else begin
      m_done = 0;
      m_dz   = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; m_hi = p_hi; m_lo = p_lo; m_done = 1; m_dz = p_dz;
        end
      end else if (start) begin
        {p_dz, p_hi, p_lo} = ref_op(op, a, b);
        m_busy = 1;
        m_cnt  = LEN + 1;
      end else begin
        if (hilo_wr[1]) m_hi = wdata;
        if (hilo_wr[0]) m_lo = wdata;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("stall", 64'(stall), 64'(m_busy & (hilo_rd | start)));
      if (m_done) chk("div_zero", 64'(dz), 64'(m_dz));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inj, input logic [1:0] wr0, input bit chk_lo1,
                       input logic [31:0] lo1, output int cyc, output int bcyc,
                       output logic dzf);
    bit found = 0;
    cyc = 0; bcyc = 0; dzf = 0;
    start = 1; op = o; a = x; b = y; hilo_wr = wr0; wdata = 32'h9999_9999;
    step();
    start = 0; hilo_wr = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      if (busy) bcyc++;
      if (inj && k == 10) chk("stall_in_run", 64'(stall), 64'd1);
      if (chk_lo1 && (k == 1 || k == 20)) chk("lo_hold", 64'(lo), 64'(lo1));
      if (done) begin
        found = 1; cyc = k; dzf = dz;
        if (inj) chk("stall_in_done", 64'(stall), 64'd0);
        break;
      end
      step();
      if (inj) begin
        hilo_rd = 1;
        if (k >= 3 && k <= 20) begin
          start = 1; op = 2'd0; a = 3; b = 3; hilo_wr = 2'b01; wdata = 32'hDEAD_BEEF;
        end else begin
          start = 0; hilo_wr = '0;
        end
      end
    end
    if (!found) chk("done_timeout", 64'd0, 64'd1);
    step();
    start = 0; hilo_rd = 0; hilo_wr = '0;
  endtask

  int   cyc, bcyc;
  logic dzf;

  initial begin
    #1 rst = 1;
    #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 0;

    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_lo", 64'(lo), 64'h00000001);
    chk("multu_done_cycle", 64'(cyc), 64'd34);
    chk("multu_busy_cycles", 64'(bcyc), 64'd33);

    do_op(2'd1, 32'hFFFFFFFD, 32'd7, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFEB);

    do_op(2'd3, 32'hFFFFFFF9, 32'd2, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);

    do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("div_ovf_lo", 64'(lo), 64'h80000000);
    chk("div_ovf_hi", 64'(hi), 64'd0);
    chk("div_ovf_flag", 64'(dzf), 64'd0);

    do_op(2'd2, 32'd10, 32'd0, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("divz_hi", 64'(hi), 64'h0000000A);
    chk("divz_lo", 64'(lo), 64'hFFFFFFFF);
    chk("divz_flag", 64'(dzf), 64'd1);

    // Stall, restart and MTLO attempts during an operation
    do_op(2'd2, 32'd100, 32'd7, 1, 2'b00, 1, 32'hFFFFFFFF, cyc, bcyc, dzf);
    chk("inj_lo", 64'(lo), 64'd14);
    chk("inj_hi", 64'(hi), 64'd2);

    hilo_wr = 2'b10; wdata = 32'h1234; step();
    hilo_wr = 2'b01; wdata = 32'h5678; step();
    hilo_wr = '0;
    chk("mthi", 64'(hi), 64'h1234);
    chk("mtlo", 64'(lo), 64'h5678);

    do_op(2'd0, 32'd2, 32'd3, 0, 2'b01, 1, 32'h5678, cyc, bcyc, dzf);
    chk("wr_start_lo", 64'(lo), 64'd6);
    chk("wr_start_hi", 64'(hi), 64'd0);

    // Reset in the middle of RUN
    start = 1; op = 2'd0; a = 5; b = 9; step();
    start = 0;
    repeat (10) step();
    @(posedge clk);
    #1 rst = 1;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    #1 rst = 0;
    step();
    do_op(2'd0, 32'd6, 32'd7, 0, 2'b00, 0, '0, cyc, bcyc, dzf);
    chk("after_rst_lo", 64'(lo), 64'd42);
    chk("after_rst_hi", 64'(hi), 64'd0);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] pick [5];
      pick[0] = $urandom; pick[1] = 32'h80000000; pick[2] = 32'hFFFFFFFF;
      pick[3] = 32'd0;    pick[4] = $urandom_range(0, 20);
      start   = ($urandom_range(0, 9) == 0);
      op      = 2'($urandom_range(0, 3));
      a       = pick[$urandom_range(0, 4)];
      b       = pick[$urandom_range(0, 4)];
      hilo_wr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      wdata   = $urandom;
      hilo_rd = ($urandom_range(0, 3) == 0);
      step();
    end
    start = 0; hilo_wr = '0; hilo_rd = 0;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
